// File: rtl/gfx_pkg.sv
// Shared definitions for the frame blitter: sequencer states, frame geometry
// and the frame-index to RAM-base mapping.
package gfx_pkg;

   localparam int FRAME_WORDS  = 1024;
   localparam int VRAM_AW      = 16;
   localparam int PKG_RAM_AW   = 12;
   localparam int PKG_FRAME_AW = 10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COPY,
      ST_DRAIN,
      ST_FINISH
   } state_e;

   // Frame index occupies the top RAM address bits.
   function automatic logic [PKG_RAM_AW-1:0] frame_base(input logic [1:0] frame);
      return {frame, {PKG_FRAME_AW{1'b0}}};
   endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// Shares the single RAM port between the CPU (priority) and the DMA copy loop.
// A starve counter forces one DMA slot after STARVE_MAX consecutive CPU wins.
module ram_port_arbiter #(
   parameter int STARVE_MAX = 15
) (
   input  logic CLK,
   input  logic RESET,
   input  logic cpu_req_i,
   input  logic dma_want_i,
   output logic cpu_gnt_o,
   output logic dma_slot_o
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [SW-1:0] starve_q, starve_d;
   logic          starved;

   assign starved    = dma_want_i && (starve_q == SW'(STARVE_MAX));
   assign cpu_gnt_o  = cpu_req_i && !starved;
   assign dma_slot_o = dma_want_i && !cpu_gnt_o;

   // Only a run of CPU wins during a copy accumulates; any DMA slot restarts it.
   always_comb begin
      starve_d = starve_q;
      if (!dma_want_i || dma_slot_o) begin
         starve_d = '0;
      end else if (starve_q != SW'(STARVE_MAX)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/frame_blit_dma.sv
// Copies one frame from main RAM into VRAM (one read per granted slot, write one
// cycle later), then pulses gpu_draw/done. Rejected starts pulse skip.
module frame_blit_dma
   import gfx_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int RAM_AW     = 12,
   parameter int FRAME_AW   = 10,
   parameter int STARVE_MAX = 15
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                start,
   input  logic [1:0]          frame_sel,
   output logic                busy,
   output logic                done,
   output logic                skip,
   input  logic                gpu_ready,
   output logic                gpu_draw,
   output logic                ram_en,
   output logic [RAM_AW-1:0]   ram_addr,
   input  logic [DATA_W-1:0]   ram_rdata,
   output logic                vram_en,
   output logic                vram_we,
   output logic [VRAM_AW-1:0]  vram_addr,
   output logic [DATA_W-1:0]   vram_wdata,
   input  logic                cpu_req,
   output logic                cpu_gnt
);

   localparam logic [FRAME_AW:0] LAST_CNT = (FRAME_AW+1)'((1 << FRAME_AW) - 1);

   state_e              state_q, state_d;
   logic [RAM_AW-1:0]   base_q, base_d;
   logic [FRAME_AW:0]   cnt_q, cnt_d;
   logic                wr_vld_q;
   logic [FRAME_AW-1:0] wr_addr_q;
   logic                skip_q;
   logic                dma_want;
   logic                dma_slot;

   assign dma_want = (state_q == ST_COPY);

   ram_port_arbiter #(
      .STARVE_MAX (STARVE_MAX)
   ) u_arb (
      .CLK        (CLK),
      .RESET      (RESET),
      .cpu_req_i  (cpu_req),
      .dma_want_i (dma_want),
      .cpu_gnt_o  (cpu_gnt),
      .dma_slot_o (dma_slot)
   );

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      cnt_d    = cnt_q;
      busy     = (state_q != ST_IDLE);
      done     = (state_q == ST_FINISH);
      gpu_draw = (state_q == ST_FINISH);
      ram_en   = dma_slot;
      ram_addr = '0;
      case (state_q)
         ST_IDLE: begin
            if (start && gpu_ready) begin
               base_d  = RAM_AW'(frame_base(frame_sel));
               cnt_d   = '0;
               state_d = ST_COPY;
            end
         end
         ST_COPY: begin
            if (dma_slot) begin
               // OR rather than add: the offset never carries into the frame bits.
               ram_addr = base_q | RAM_AW'(cnt_q[FRAME_AW-1:0]);
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN:  state_d = ST_FINISH;
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         base_q    <= '0;
         cnt_q     <= '0;
         wr_vld_q  <= 1'b0;
         wr_addr_q <= '0;
         skip_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         cnt_q    <= cnt_d;
         wr_vld_q <= dma_slot;
         if (dma_slot) begin
            wr_addr_q <= cnt_q[FRAME_AW-1:0];
         end
         skip_q <= (state_q == ST_IDLE) && start && !gpu_ready;
      end
   end

   // RAM data arrives the cycle after the read, so it feeds VRAM directly.
   assign skip       = skip_q;
   assign vram_en    = wr_vld_q;
   assign vram_we    = wr_vld_q;
   assign vram_addr  = wr_vld_q ? {{(VRAM_AW-FRAME_AW){1'b0}}, wr_addr_q} : '0;
   assign vram_wdata = wr_vld_q ? ram_rdata : '0;

endmodule

// File: tb/tb_frame_blit_dma.sv
// Bench for frame_blit_dma: RAM model holding data = address, scoreboard of
// expected VRAM writes, and per-scenario timing checks.
module tb_frame_blit_dma;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
   } wr_t;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  frame_sel = 2'd0;
   logic        busy, done, skip, gpu_draw, ram_en;
   logic        gpu_ready = 1'b0;
   logic [11:0] ram_addr;
   logic [15:0] ram_rdata = 16'd0;
   logic        vram_en, vram_we;
   logic [15:0] vram_addr, vram_wdata;
   logic        cpu_req = 1'b0;
   logic        cpu_gnt;

   logic [15:0] mem [4096];
   wr_t         sb_q [$];

   int checks = 0;
   int failures = 0;

   int r_first_addr, r_last_addr, r_reads, r_writes, r_first_wcyc, r_last_wcyc;
   int r_last_waddr, r_last_wdata, r_done_cyc, r_draw_cyc, r_done_cnt, r_draw_cnt;
   int r_busy_last, r_skip_cyc, r_skip_cnt, r_gnt_low, r_gnt_bad, r_range_bad;
   int r_pair_bad, r_we_after_rst, r_sb_left;

   frame_blit_dma dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .start      (start),
      .frame_sel  (frame_sel),
      .busy       (busy),
      .done       (done),
      .skip       (skip),
      .gpu_ready  (gpu_ready),
      .gpu_draw   (gpu_draw),
      .ram_en     (ram_en),
      .ram_addr   (ram_addr),
      .ram_rdata  (ram_rdata),
      .vram_en    (vram_en),
      .vram_we    (vram_we),
      .vram_addr  (vram_addr),
      .vram_wdata (vram_wdata),
      .cpu_req    (cpu_req),
      .cpu_gnt    (cpu_gnt)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (ram_en) ram_rdata <= mem[ram_addr];
   end

   // Cycle 0 is the cycle in which start is high; cycle k is observed at the k-th
   // falling edge after it. Inputs for cycle k are applied at that falling edge.
   task automatic run_copy(input logic [1:0] fsel, input logic rdy, input int cpu_lo,
                           input int cpu_hi, input int rst_at, input int st2_at,
                           input int st3_at, input int budget);
      wr_t e;
      int  base;
      base = int'(fsel) * 1024;
      r_first_addr = -1; r_last_addr = -1; r_reads = 0; r_writes = 0;
      r_first_wcyc = -1; r_last_wcyc = -1; r_last_waddr = -1; r_last_wdata = -1;
      r_done_cyc = -1; r_draw_cyc = -1; r_done_cnt = 0; r_draw_cnt = 0;
      r_busy_last = -1; r_skip_cyc = -1; r_skip_cnt = 0; r_gnt_low = 0; r_gnt_bad = 0;
      r_range_bad = 0; r_pair_bad = 0; r_we_after_rst = 0;
      sb_q.delete();
      @(negedge CLK);
      frame_sel = fsel; gpu_ready = rdy; start = 1'b1; cpu_req = 1'b0;
      if (rdy) begin
         for (int i = 0; i < 1024; i++) begin
            e.addr = 16'(i);
            e.data = 16'(base + i);
            sb_q.push_back(e);
         end
      end
      for (int k = 1; k <= budget; k++) begin
         @(negedge CLK);
         start = (k == st2_at) || (k == st3_at);
         if (start) frame_sel = 2'd0;
         cpu_req = (k >= cpu_lo) && (k <= cpu_hi);
         RESET = (k == rst_at);
         #1;
         if (ram_en) begin
            if (r_reads == 0) r_first_addr = int'(ram_addr);
            r_last_addr = int'(ram_addr);
            r_reads++;
            if (int'(ram_addr) < base || int'(ram_addr) > base + 1023) r_range_bad++;
         end
         if (cpu_req && !cpu_gnt) begin
            r_gnt_low++;
            if (k % 16 != 0) r_gnt_bad++;
         end
         if (vram_en !== vram_we) r_pair_bad++;
         if (vram_we) begin
            r_writes++;
            if (r_first_wcyc < 0) r_first_wcyc = k;
            r_last_wcyc = k;
            r_last_waddr = int'(vram_addr);
            r_last_wdata = int'(vram_wdata);
            if (rst_at > 0 && k > rst_at) r_we_after_rst++;
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected_write cycle=%0d got addr=%h data=%h exp none", k, vram_addr, vram_wdata);
            end else begin
               e = sb_q.pop_front();
               if (vram_addr !== e.addr || vram_wdata !== e.data) begin
                  failures++;
                  $display("FAIL sb_write cycle=%0d got addr=%h data=%h exp addr=%h data=%h", k, vram_addr, vram_wdata, e.addr, e.data);
               end
            end
         end
         if (done) begin r_done_cnt++; if (r_done_cyc < 0) r_done_cyc = k; end
         if (gpu_draw) begin r_draw_cnt++; if (r_draw_cyc < 0) r_draw_cyc = k; end
         if (busy) r_busy_last = k;
         if (skip) begin r_skip_cnt++; if (r_skip_cyc < 0) r_skip_cyc = k; end
      end
      r_sb_left = sb_q.size();
      start = 1'b0; cpu_req = 1'b0; RESET = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1; cpu_req = 1'b0;
      repeat (3) @(negedge CLK);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0 || gpu_draw !== 1'b0) begin failures++; $display("FAIL rst_done_draw got=%b%b exp=00", done, gpu_draw); end
      checks++; if (skip !== 1'b0) begin failures++; $display("FAIL rst_skip got=%b exp=0", skip); end
      checks++; if (ram_en !== 1'b0 || ram_addr !== 12'h000) begin failures++; $display("FAIL rst_ram got en=%b addr=%h exp 0/000", ram_en, ram_addr); end
      checks++; if (vram_en !== 1'b0 || vram_we !== 1'b0) begin failures++; $display("FAIL rst_vram_strobes got=%b%b exp=00", vram_en, vram_we); end
      checks++; if (vram_addr !== 16'h0 || vram_wdata !== 16'h0) begin failures++; $display("FAIL rst_vram_bus got addr=%h data=%h exp 0/0", vram_addr, vram_wdata); end
      checks++; if (cpu_gnt !== 1'b0) begin failures++; $display("FAIL rst_gnt_idle got=%b exp=0", cpu_gnt); end
      cpu_req = 1'b1; #1;
      checks++; if (cpu_gnt !== 1'b1) begin failures++; $display("FAIL rst_gnt_req got=%b exp=1", cpu_gnt); end
      @(negedge CLK);
      cpu_req = 1'b0; RESET = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_basic_copy();
      run_copy(2'd2, 1'b1, 0, -1, 0, 0, 0, 1032);
      checks++; if (r_first_addr !== 'h800) begin failures++; $display("FAIL basic_first_raddr got=%0h exp=800", r_first_addr); end
      checks++; if (r_reads !== 1024) begin failures++; $display("FAIL basic_reads got=%0d exp=1024", r_reads); end
      checks++; if (r_first_wcyc !== 2 || r_last_wcyc !== 1025) begin failures++; $display("FAIL basic_write_window got=%0d..%0d exp=2..1025", r_first_wcyc, r_last_wcyc); end
      checks++; if (r_last_waddr !== 'h3FF || r_last_wdata !== 'h0BFF) begin failures++; $display("FAIL basic_last_write got addr=%0h data=%0h exp 3ff/bff", r_last_waddr, r_last_wdata); end
      checks++; if (r_draw_cyc !== 1026 || r_draw_cnt !== 1) begin failures++; $display("FAIL basic_draw got cyc=%0d cnt=%0d exp 1026/1", r_draw_cyc, r_draw_cnt); end
      checks++; if (r_done_cyc !== 1026 || r_done_cnt !== 1) begin failures++; $display("FAIL basic_done got cyc=%0d cnt=%0d exp 1026/1", r_done_cyc, r_done_cnt); end
      checks++; if (r_busy_last !== 1026) begin failures++; $display("FAIL basic_busy_last got=%0d exp=1026", r_busy_last); end
      checks++; if (r_sb_left !== 0 || r_pair_bad !== 0) begin failures++; $display("FAIL basic_all_written got left=%0d pair_bad=%0d exp 0/0", r_sb_left, r_pair_bad); end
   endtask

   task automatic test_skip();
      run_copy(2'd0, 1'b0, 0, -1, 0, 0, 0, 8);
      checks++; if (r_skip_cyc !== 1 || r_skip_cnt !== 1) begin failures++; $display("FAIL skip_pulse got cyc=%0d cnt=%0d exp 1/1", r_skip_cyc, r_skip_cnt); end
      checks++; if (r_reads !== 0 || r_writes !== 0) begin failures++; $display("FAIL skip_no_traffic got reads=%0d writes=%0d exp 0/0", r_reads, r_writes); end
      checks++; if (r_draw_cnt !== 0 || r_busy_last !== -1) begin failures++; $display("FAIL skip_idle got draws=%0d busy_last=%0d exp 0/-1", r_draw_cnt, r_busy_last); end
   endtask

   task automatic test_cpu_starve();
      run_copy(2'd0, 1'b1, 1, 100000, 0, 0, 0, 16392);
      checks++; if (r_done_cyc !== 16386) begin failures++; $display("FAIL starve_done got=%0d exp=16386", r_done_cyc); end
      checks++; if (r_gnt_low !== 1024 || r_gnt_bad !== 0) begin failures++; $display("FAIL starve_gnt_pattern got low=%0d off_grid=%0d exp 1024/0", r_gnt_low, r_gnt_bad); end
      checks++; if (r_reads !== 1024 || r_sb_left !== 0) begin failures++; $display("FAIL starve_copy got reads=%0d left=%0d exp 1024/0", r_reads, r_sb_left); end
   endtask

   task automatic test_cpu_pulse();
      run_copy(2'd0, 1'b1, 100, 109, 0, 0, 0, 1040);
      checks++; if (r_done_cyc !== 1036) begin failures++; $display("FAIL pulse_done got=%0d exp=1036", r_done_cyc); end
      checks++; if (r_writes !== 1024 || r_sb_left !== 0) begin failures++; $display("FAIL pulse_writes got=%0d left=%0d exp 1024/0", r_writes, r_sb_left); end
      checks++; if (r_gnt_low !== 0) begin failures++; $display("FAIL pulse_cpu_denied got=%0d exp=0", r_gnt_low); end
   endtask

   task automatic test_reset_mid_copy();
      run_copy(2'd2, 1'b1, 0, -1, 500, 0, 0, 520);
      checks++; if (r_last_wcyc !== 500 || r_we_after_rst !== 0) begin failures++; $display("FAIL rstmid_writes_stop got last=%0d after=%0d exp 500/0", r_last_wcyc, r_we_after_rst); end
      checks++; if (r_writes !== 499) begin failures++; $display("FAIL rstmid_write_count got=%0d exp=499", r_writes); end
      checks++; if (r_busy_last !== 500) begin failures++; $display("FAIL rstmid_busy got last=%0d exp=500", r_busy_last); end
      checks++; if (r_draw_cnt !== 0 || r_done_cnt !== 0) begin failures++; $display("FAIL rstmid_no_draw got draw=%0d done=%0d exp 0/0", r_draw_cnt, r_done_cnt); end
      run_copy(2'd1, 1'b1, 0, -1, 0, 0, 0, 1030);
      checks++; if (r_first_addr !== 'h400) begin failures++; $display("FAIL rstmid_next_base got=%0h exp=400", r_first_addr); end
      checks++; if (r_sb_left !== 0 || r_done_cyc !== 1026) begin failures++; $display("FAIL rstmid_next_copy got left=%0d done=%0d exp 0/1026", r_sb_left, r_done_cyc); end
   endtask

   task automatic test_back_to_back();
      run_copy(2'd3, 1'b1, 0, -1, 0, 300, 1026, 1032);
      checks++; if (r_done_cnt !== 1) begin failures++; $display("FAIL b2b_single_done got=%0d exp=1", r_done_cnt); end
      checks++; if (r_first_addr !== 'hC00 || r_last_addr !== 'hFFF) begin failures++; $display("FAIL b2b_f3_range got=%0h..%0h exp c00..fff", r_first_addr, r_last_addr); end
      checks++; if (r_range_bad !== 0 || r_reads !== 1024) begin failures++; $display("FAIL b2b_f3_nowrap got bad=%0d reads=%0d exp 0/1024", r_range_bad, r_reads); end
      checks++; if (r_last_wdata !== 'h0FFF || r_sb_left !== 0) begin failures++; $display("FAIL b2b_f3_data got last=%0h left=%0d exp fff/0", r_last_wdata, r_sb_left); end
      checks++; if (r_busy_last !== 1026) begin failures++; $display("FAIL b2b_finish_start_ignored got busy_last=%0d exp=1026", r_busy_last); end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 16'(i);
      test_reset();
      test_basic_copy();
      test_skip();
      test_cpu_starve();
      test_cpu_pulse();
      test_reset_mid_copy();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
